// File: rtl/mux_8x1_rr_if.sv
// Bus bundle for the round-robin 8-to-1 stream multiplexer.
//
// Handshake rule, the same on every channel: a word moves on a rising
// clock edge where valid && ready are both 1. A source holds valid and
// its data stable until that edge. ready may depend on valid, but valid
// never depends on ready.
//
// Signals:
//   in_data   8*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
//   in_valid  8         channel i presents a word
//   in_ready  8         one-hot or zero; the word of that channel is taken
//   out_data  DATA_W    registered output word
//   out_sel   3         source channel index of out_data
//   out_valid 1         out_data/out_sel hold a word
//   out_ready 1         downstream accepts the word this cycle
//
// Modports: slave is the multiplexer's view. master is the view of the
// environment that drives the sources and the sink.
interface mux_8x1_rr_if #(
  parameter int DATA_W = 8
);
  logic [8*DATA_W-1:0] in_data;
  logic [7:0]          in_valid;
  logic [7:0]          in_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_8x1_rr.sv
// Round-robin 8-to-1 stream multiplexer with a registered output slot.
// Each word leaves tagged with its 3-bit source channel index.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       mux_8x1_rr_if.slave (input channels and the output stream)
//   dbg_full  1 when the output slot holds a word (FULL state)
//   dbg_ptr   current round-robin search start channel
module mux_8x1_rr #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_8x1_rr_if.slave    bus,
  output logic           dbg_full,
  output logic [2:0]     dbg_ptr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        sel_q;

  logic              load;
  logic              found;
  logic [2:0]        g;
  logic [2:0]        idx;
  logic [DATA_W-1:0] word;

  // The slot can take a new word when empty or when it drains this cycle.
  assign load = (state == EMPTY) || bus.out_ready;

  // Rotating priority search: first valid channel at or above ptr, wrapping 7->0.
  always_comb begin
    found = 1'b0;
    g     = ptr;
    idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + k[2:0];
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load && found) bus.in_ready[g] = 1'b1;
  end

  assign word = bus.in_data[int'(g)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      ptr    <= 3'd0;
      data_q <= '0;
      sel_q  <= 3'd0;
    end else if (load && found) begin
      // Covers both the fill from EMPTY and the bubble-free reload while draining.
      state  <= FULL;
      data_q <= word;
      sel_q  <= g;
      ptr    <= g + 3'd1;
    end else if (state == FULL && bus.out_ready) begin
      // Drain with nothing to replace it; keep data and sel as they were.
      state <= EMPTY;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = (state == FULL);
  assign dbg_full      = (state == FULL);
  assign dbg_ptr       = ptr;

endmodule

// File: tb/tb_mux_8x1_rr.sv
module tb_mux_8x1_rr;

  localparam int DATA_W = 8;

  logic clk;
  logic rst;
  logic dbg_full;
  logic [2:0] dbg_ptr;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_q[$];

  mux_8x1_rr_if #(.DATA_W(DATA_W)) bus ();

  mux_8x1_rr #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .dbg_full (dbg_full),
    .dbg_ptr  (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle so registered outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic set_ch(input int ch, input logic [DATA_W-1:0] d);
    bus.in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 8'h00) begin
      errors++; $display("FAIL reset_in_ready got=%h exp=00", bus.in_ready);
    end
    step();
    bus.in_valid = 8'h00;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 3'd0 || dbg_ptr !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got valid=%b data=%h sel=%0d ptr=%0d exp valid=0 data=00 sel=0 ptr=0",
               bus.out_valid, bus.out_data, bus.out_sel, dbg_ptr);
    end
  endtask

  task automatic test_single();
    set_ch(3, 8'hA5);
    bus.in_valid  = 8'h08;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 8'h08) begin
      errors++; $display("FAIL single_in_ready got=%h exp=08", bus.in_ready);
    end
    step();
    bus.in_valid = 8'h00;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_sel !== 3'd3 || dbg_ptr !== 3'd4) begin
      errors++;
      $display("FAIL single_out got valid=%b data=%h sel=%0d ptr=%0d exp valid=1 data=a5 sel=3 ptr=4",
               bus.out_valid, bus.out_data, bus.out_sel, dbg_ptr);
    end
  endtask

  task automatic test_drain();
    // The slot holds ch3/A5 from the previous scenario.
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sel !== 3'd3 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL drain got valid=%b sel=%0d data=%h exp valid=0 sel=3 data=a5",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_all_channels();
    logic [10:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) set_ch(i, 8'h10 + 8'(i));
    for (int n = 0; n < 10; n++) exp_q.push_back({3'(n % 8), 8'h10 + 8'(n % 8)});
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== e[10:8] || bus.out_data !== e[7:0]) begin
        errors++;
        $display("FAIL all_ch[%0d] got valid=%b sel=%0d data=%h exp valid=1 sel=%0d data=%h",
                 n, bus.out_valid, bus.out_sel, bus.out_data, e[10:8], e[7:0]);
      end
    end
    bus.in_valid = 8'h00;
    step();
  endtask

  task automatic test_backpressure();
    set_ch(5, 8'h55);
    set_ch(2, 8'h22);
    bus.in_valid  = 8'h20;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 8'h04;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++;
      if (bus.in_ready !== 8'h00 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h55 || bus.out_sel !== 3'd5) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rdy=%h valid=%b data=%h sel=%0d exp rdy=00 valid=1 data=55 sel=5",
                 n, bus.in_ready, bus.out_valid, bus.out_data, bus.out_sel);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 8'h04) begin
      errors++; $display("FAIL bp_release_rdy got=%h exp=04", bus.in_ready);
    end
    step();
    bus.in_valid = 8'h00;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd2 || bus.out_data !== 8'h22) begin
      errors++;
      $display("FAIL bp_next got valid=%b sel=%0d data=%h exp valid=1 sel=2 data=22",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
    step();
  endtask

  task automatic test_wrap();
    // Route one word from ch6 so ptr lands on 7.
    set_ch(6, 8'h66);
    bus.in_valid  = 8'h40;
    bus.out_ready = 1'b1;
    step();
    set_ch(7, 8'hF7);
    set_ch(0, 8'h0F);
    bus.in_valid = 8'h81;
    #1;
    checks++;
    if (dbg_ptr !== 3'd7 || bus.in_ready !== 8'h80) begin
      errors++; $display("FAIL wrap_start got ptr=%0d rdy=%h exp ptr=7 rdy=80", dbg_ptr, bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_sel !== 3'd7 || bus.out_data !== 8'hF7 || dbg_ptr !== 3'd0) begin
      errors++; $display("FAIL wrap_g7 got sel=%0d data=%h ptr=%0d exp sel=7 data=f7 ptr=0", bus.out_sel, bus.out_data, dbg_ptr);
    end
    step();
    checks++;
    if (bus.out_sel !== 3'd0 || bus.out_data !== 8'h0F || dbg_ptr !== 3'd1) begin
      errors++; $display("FAIL wrap_g0 got sel=%0d data=%h ptr=%0d exp sel=0 data=0f ptr=1", bus.out_sel, bus.out_data, dbg_ptr);
    end
    step();
    checks++;
    if (bus.out_sel !== 3'd7 || dbg_ptr !== 3'd0) begin
      errors++; $display("FAIL wrap_g7b got sel=%0d ptr=%0d exp sel=7 ptr=0", bus.out_sel, dbg_ptr);
    end
    bus.in_valid = 8'h00;
    step();
  endtask

  task automatic test_mid_reset();
    set_ch(4, 8'h44);
    bus.in_valid  = 8'h10;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 8'h00;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd4) begin
      errors++; $display("FAIL mid_fill got valid=%b sel=%0d exp valid=1 sel=4", bus.out_valid, bus.out_sel);
    end
    set_ch(0, 8'h0A);
    set_ch(6, 8'h6A);
    rst = 1'b1;
    bus.in_valid  = 8'h41;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 8'h00) begin
      errors++; $display("FAIL mid_rst_rdy got=%h exp=00", bus.in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 3'd0 || dbg_ptr !== 3'd0) begin
      errors++;
      $display("FAIL mid_rst_state got valid=%b data=%h sel=%0d ptr=%0d exp valid=0 data=00 sel=0 ptr=0",
               bus.out_valid, bus.out_data, bus.out_sel, dbg_ptr);
    end
    checks++;
    if (bus.in_ready !== 8'h01) begin
      errors++; $display("FAIL mid_rst_grant got=%h exp=01", bus.in_ready);
    end
    step();
    bus.in_valid = 8'h00;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd0 || bus.out_data !== 8'h0A) begin
      errors++;
      $display("FAIL mid_rst_first got valid=%b sel=%0d data=%h exp valid=1 sel=0 data=0a",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_drain();
    test_all_channels();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
